// File: rtl/sdram_copy_dma.sv
// sdram_copy_dma: Avalon-MM block copy from SDRAM1 to SDRAM2 through a credit-limited FIFO
module sdram_copy_dma #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 16,
   parameter int LEN_W      = 24,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   src_addr,
   input  logic [ADDR_W-1:0]   dst_addr,
   input  logic [LEN_W-1:0]    len,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   rd_address,
   output logic                rd_read,
   input  logic                rd_waitrequest,
   input  logic [DATA_W-1:0]   rd_readdata,
   input  logic                rd_readdatavalid,
   output logic [ADDR_W-1:0]   wr_address,
   output logic                wr_write,
   output logic [DATA_W-1:0]   wr_writedata,
   output logic [DATA_W/8-1:0] wr_byteenable,
   input  logic                wr_waitrequest
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = CW + 1;
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [LEN_W-1:0] len_q, len_d, reads_q, reads_d, writes_q, writes_d;
   logic [CW-1:0] inflight_q, inflight_d, count_q, count_d;
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic run, rd_acc, wr_acc, push;
   assign run = state_q == RUN;
   assign busy = run;
   assign done = state_q == DONE;
   assign rd_read = run && reads_q < len_q && ({1'b0, count_q} + {1'b0, inflight_q}) < SW'(FIFO_DEPTH);
   assign wr_write = run && count_q != '0;
   assign rd_acc = rd_read && !rd_waitrequest;
   assign wr_acc = wr_write && !wr_waitrequest;
   assign push = run && rd_readdatavalid;
   assign rd_address = rd_addr_q;
   assign wr_address = wr_addr_q;
   assign wr_writedata = wr_write ? mem_q[rptr_q] : '0;
   assign wr_byteenable = '1;
   // next-state: counters advance on handshakes, a start in IDLE reloads everything
   always_comb begin
      state_d = state_q;
      len_d = len_q;
      rd_addr_d = rd_addr_q + (rd_acc ? STEP : '0);
      wr_addr_d = wr_addr_q + (wr_acc ? STEP : '0);
      reads_d = reads_q + LEN_W'(rd_acc);
      writes_d = writes_q + LEN_W'(wr_acc);
      inflight_d = inflight_q + CW'(rd_acc) - CW'(push);
      count_d = count_q + CW'(push) - CW'(wr_acc);
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(wr_acc);
      case (state_q)
         IDLE: if (start) begin
            state_d = len == '0 ? DONE : RUN;
            len_d = len;
            rd_addr_d = src_addr;
            wr_addr_d = dst_addr;
            reads_d = '0;
            writes_d = '0;
            inflight_d = '0;
            count_d = '0;
            wptr_d = '0;
            rptr_d = '0;
         end
         RUN: state_d = wr_acc && writes_q == len_q - LEN_W'(1) ? DONE : RUN;
         default: state_d = IDLE;
      endcase
   end
   // state and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         len_q <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         reads_q <= '0;
         writes_q <= '0;
         inflight_q <= '0;
         count_q <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         state_q <= state_d;
         len_q <= len_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         reads_q <= reads_d;
         writes_q <= writes_d;
         inflight_q <= inflight_d;
         count_q <= count_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end
   // FIFO storage; contents need no reset because the read side is gated by count
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= rd_readdata;
   end
endmodule

// File: tb/tb_sdram_copy_dma.sv
// tb_sdram_copy_dma: vector table of copies against an SDRAM slave model and write scoreboard
module tb_sdram_copy_dma;
   logic clk = 0, reset = 1, start = 0;
   logic [31:0] src_addr = 0, dst_addr = 0, rd_address, wr_address;
   logic [23:0] len = 0;
   logic busy, done, rd_read, rd_waitrequest = 0, rd_readdatavalid = 0, wr_write, wr_waitrequest = 0;
   logic [15:0] rd_readdata = 0, wr_writedata;
   logic [1:0] wr_byteenable;
   typedef struct {logic [15:0] data; int due;} rsp_t;
   typedef struct {logic [31:0] addr; logic [15:0] data;} wr_t;
   typedef struct {logic [31:0] src, dst; int len, lat_lo, lat_hi; bit rnd; int hold, restart, exp_writes; bit exp_full;} vec_t;
   rsp_t pend[$];
   wr_t exp_q[$];
   vec_t vecs[6];
   int n_chk = 0, n_pass = 0, cycle = 0, reads_acc = 0, writes_acc = 0, peak = 0, done_cnt = 0;
   int lat_lo = 1, lat_hi = 1, hold_until = 0, last_due = 0, lat, due;
   bit rnd = 0, prev_rd_stall = 0, prev_wr_stall = 0;
   logic [31:0] exp_rd_addr = 0, prev_rd_addr, prev_wr_addr;
   logic [15:0] prev_wr_data;

   sdram_copy_dma dut (.clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .len(len), .busy(busy), .done(done), .rd_address(rd_address), .rd_read(rd_read),
      .rd_waitrequest(rd_waitrequest), .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid),
      .wr_address(wr_address), .wr_write(wr_write), .wr_writedata(wr_writedata),
      .wr_byteenable(wr_byteenable), .wr_waitrequest(wr_waitrequest));

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_f(input logic [31:0] a);
      return a[15:0] * 16'd7 ^ a[31:16] ^ 16'h1234;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic nx;
      @(negedge clk);
      #1;
   endtask

   // SDRAM slave models plus bus monitor, evaluated away from the active edge
   initial forever begin
      @(negedge clk);
      cycle++;
      rd_waitrequest = rnd ? $urandom_range(0, 2) == 0 : 1'b0;
      wr_waitrequest = rnd ? $urandom_range(0, 2) == 0 : 1'b0;
      if (cycle < hold_until) wr_waitrequest = 1;
      if (pend.size() != 0 && pend[0].due <= cycle) begin
         rd_readdatavalid = 1;
         rd_readdata = pend[0].data;
         void'(pend.pop_front());
      end else begin
         rd_readdatavalid = 0;
         rd_readdata = 0;
      end
      if (reset) begin
         prev_rd_stall = 0;
         prev_wr_stall = 0;
      end else begin
         if (prev_rd_stall) chk("rd_stall_hold", {rd_read, rd_address}, {1'b1, prev_rd_addr});
         if (prev_wr_stall) chk("wr_stall_hold", {wr_write, wr_address, wr_writedata}, {1'b1, prev_wr_addr, prev_wr_data});
         prev_rd_stall = rd_read && rd_waitrequest;
         prev_rd_addr = rd_address;
         prev_wr_stall = wr_write && wr_waitrequest;
         prev_wr_addr = wr_address;
         prev_wr_data = wr_writedata;
         if (rd_read && !rd_waitrequest) begin
            chk("rd_addr", rd_address, exp_rd_addr);
            exp_rd_addr += 2;
            reads_acc++;
            lat = $urandom_range(lat_lo, lat_hi);
            due = cycle + lat > last_due + 1 ? cycle + lat : last_due + 1;
            last_due = due;
            pend.push_back('{mem_f(rd_address), due});
            if (reads_acc - writes_acc > peak) peak = reads_acc - writes_acc;
            chk("credit", reads_acc - writes_acc <= 8, 1);
         end
         if (wr_write && !wr_waitrequest) begin
            writes_acc++;
            chk("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               chk("wr_addr", wr_address, exp_q[0].addr);
               chk("wr_data", wr_writedata, exp_q[0].data);
               void'(exp_q.pop_front());
            end
         end
         if (done) begin
            done_cnt++;
            chk("busy_low_in_done", busy, 0);
         end
      end
   end

   task automatic arm(input vec_t v);
      exp_rd_addr = v.src;
      reads_acc = 0;
      writes_acc = 0;
      peak = 0;
      done_cnt = 0;
      lat_lo = v.lat_lo;
      lat_hi = v.lat_hi;
      rnd = v.rnd;
      exp_q.delete();
      for (int i = 0; i < v.len; i++) exp_q.push_back('{v.dst + 32'(2 * i), mem_f(v.src + 32'(2 * i))});
   endtask

   task automatic run_xfer(input vec_t v);
      int n;
      arm(v);
      nx();
      start = 1;
      src_addr = v.src;
      dst_addr = v.dst;
      len = 24'(v.len);
      hold_until = cycle + 1 + v.hold;
      nx();
      start = 0;
      chk("first_rd_read", rd_read, 1);
      chk("busy_after_start", busy, 1);
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         nx();
         n++;
         start = v.restart != 0 && n == v.restart;
         if (start) begin
            src_addr = 32'hDEAD0000;
            dst_addr = 32'hBEEF0000;
            len = 24'd3;
         end
      end
      start = 0;
      chk("done_timeout", done_cnt != 0, 1);
      repeat (3) nx();
      rnd = 0;
      chk("done_once", done_cnt, 1);
      chk("reads_total", reads_acc, v.len);
      chk("writes_total", writes_acc, v.exp_writes);
      chk("sb_empty", exp_q.size(), 0);
      chk("idle_outs", {busy, done, rd_read, wr_write}, 0);
      chk("peak_le_8", peak <= 8, 1);
      if (v.exp_full) chk("peak_full", peak, 8);
   endtask

   initial begin
      int n;
      vecs[0] = '{32'h0000, 32'h1000, 4, 2, 2, 0, 0, 0, 4, 0};
      vecs[1] = '{32'h2000, 32'h3000, 32, 1, 5, 1, 0, 0, 32, 0};
      vecs[2] = '{32'h0100, 32'h8000, 16, 2, 2, 0, 20, 0, 16, 1};
      vecs[3] = '{32'h0040, 32'h0500, 6, 1, 1, 0, 0, 3, 6, 0};
      vecs[4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 8, 1, 3, 0, 0, 0, 8, 0};
      vecs[5] = '{32'h0010, 32'h0020, 1, 1, 1, 0, 0, 0, 1, 0};
      repeat (3) nx();
      chk("reset_state", {busy, done, rd_read, wr_write, rd_address, wr_address, wr_writedata}, 0);
      reset = 0;
      nx();
      foreach (vecs[i]) run_xfer(vecs[i]);
      // zero-length copy: straight to DONE with no bus traffic
      arm('{32'h0, 32'h0, 0, 1, 1, 0, 0, 0, 0, 0});
      start = 1;
      len = 0;
      nx();
      start = 0;
      chk("len0_done", done, 1);
      nx();
      chk("len0_done_drop", {done, busy}, 0);
      repeat (3) nx();
      chk("len0_traffic", {reads_acc, writes_acc}, 0);
      chk("len0_done_once", done_cnt, 1);
      // reset with reads still outstanding
      arm('{32'h4000, 32'h6000, 16, 4, 4, 0, 0, 0, 16, 0});
      start = 1;
      src_addr = 32'h4000;
      dst_addr = 32'h6000;
      len = 24'd16;
      nx();
      start = 0;
      n = 0;
      while (reads_acc < 3 && n < 50) begin
         nx();
         n++;
      end
      chk("rst_reads_timeout", reads_acc >= 3, 1);
      nx();
      reset = 1;
      nx();
      chk("rst_outs", {busy, done, rd_read, wr_write, rd_address, wr_address, wr_writedata}, 0);
      reset = 0;
      exp_q.delete();
      writes_acc = 0;
      reads_acc = 0;
      repeat (10) nx();
      chk("late_rdv_drained", pend.size(), 0);
      chk("no_write_after_rst", {writes_acc, reads_acc}, 0);
      run_xfer('{32'h0A00, 32'h0C00, 2, 1, 2, 0, 0, 0, 2, 0});
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
